// File: rtl/uart_loader_if.sv
// uart_loader_if: UART line plus memory write port and loader status.
//   rx        - serial line into the loader (idle high)
//   mem_addr  - 16-bit write address
//   mem_data  - 8-bit write data
//   mem_we    - one-cycle write strobe
//   cpu_hold  - high keeps the CPU in reset
//   busy      - frame in progress
//   done      - sticky, frame completed successfully
//   error     - sticky, framing or checksum error
// master: the loader side.
// slave: the memory / CPU / line side.
interface uart_loader_if;
   logic        rx;
   logic [15:0] mem_addr;
   logic [7:0]  mem_data;
   logic        mem_we;
   logic        cpu_hold;
   logic        busy;
   logic        done;
   logic        error;

   modport master (
      input  rx,
      output mem_addr, mem_data, mem_we, cpu_hold, busy, done, error
   );

   modport slave (
      output rx,
      input  mem_addr, mem_data, mem_we, cpu_hold, busy, done, error
   );
endinterface

// File: rtl/uart_loader.sv
// uart_loader: receives a framed program image over UART and writes it to
// memory at consecutive addresses, holding the CPU in reset until the
// image is complete.
//
// Frame: SYNC_BYTE, ADDR_H, ADDR_L, LEN_H, LEN_L, LEN data bytes,
//        then CSUM when UART_LOADER_CHECKSUM_EN is defined.
//
// Ports:
//   clk  - board clock
//   rst  - synchronous active-high reset
//   bus  - uart_loader_if.master (rx in; memory write port and status out)
//
// Parameters:
//   CLKS_PER_BIT - clock cycles per UART bit
//   SYNC_BYTE    - header byte that opens a frame
//
// Optional feature macro: UART_LOADER_CHECKSUM_EN adds the CSUM state and
// a modulo-256 sum of the data bytes that must match the trailing byte.
module uart_loader #(
   parameter int          CLKS_PER_BIT = 104,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   uart_loader_if.master bus
);

   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

   // ---------------------------------------------------------------
   // RX synchronizer; rx_s3 is the previous synchronized sample used
   // for falling-edge detection.
   // ---------------------------------------------------------------
   logic rx_s1, rx_s2, rx_s3;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
         rx_s3 <= 1'b1;
      end else begin
         rx_s1 <= bus.rx;
         rx_s2 <= rx_s1;
         rx_s3 <= rx_s2;
      end
   end

   // ---------------------------------------------------------------
   // RX byte receiver
   // ---------------------------------------------------------------
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   rx_state_t     rx_st, rx_st_n;
   logic [CW-1:0] rx_cnt, rx_cnt_n;
   logic [2:0]    rx_bit, rx_bit_n;
   logic [7:0]    rx_shift, rx_shift_n;
   logic          byte_valid, frame_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_st    <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
      end else begin
         rx_st    <= rx_st_n;
         rx_cnt   <= rx_cnt_n;
         rx_bit   <= rx_bit_n;
         rx_shift <= rx_shift_n;
      end
   end

   always_comb begin
      rx_st_n    = rx_st;
      rx_cnt_n   = rx_cnt + 1'b1;
      rx_bit_n   = rx_bit;
      rx_shift_n = rx_shift;
      byte_valid = 1'b0;
      frame_err  = 1'b0;
      case (rx_st)
         RX_IDLE: begin
            rx_cnt_n = '0;
            if (rx_s3 && !rx_s2) rx_st_n = RX_START;
         end
         RX_START: begin
            // Re-check the start bit at its centre to reject glitches.
            if (rx_cnt == HALF) begin
               rx_cnt_n = '0;
               rx_bit_n = '0;
               rx_st_n  = rx_s2 ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_cnt == FULL) begin
               rx_cnt_n   = '0;
               rx_shift_n = {rx_s2, rx_shift[7:1]};
               rx_bit_n   = rx_bit + 1'b1;
               if (rx_bit == 3'd7) rx_st_n = RX_STOP;
            end
         end
         RX_STOP: begin
            // Return to idle at the stop-bit centre so a start bit that
            // immediately follows one stop bit is still caught.
            if (rx_cnt == FULL) begin
               rx_cnt_n   = '0;
               byte_valid = rx_s2;
               frame_err  = !rx_s2;
               rx_st_n    = RX_IDLE;
            end
         end
         default: rx_st_n = RX_IDLE;
      endcase
   end

   // ---------------------------------------------------------------
   // Loader FSM
   // ---------------------------------------------------------------
   typedef enum logic [3:0] {
      S_IDLE, S_ADDR_H, S_ADDR_L, S_LEN_H, S_LEN_L, S_DATA,
`ifdef UART_LOADER_CHECKSUM_EN
      S_CSUM,
`endif
      S_DONE, S_ERROR
   } ld_state_t;

   // State entered once the last data byte (or an empty payload) is seen.
`ifdef UART_LOADER_CHECKSUM_EN
   localparam ld_state_t S_TAIL = S_CSUM;
`else
   localparam ld_state_t S_TAIL = S_DONE;
`endif

   ld_state_t   st, st_n;
   logic [15:0] addr, addr_n;
   logic [15:0] len, len_n;
   logic [15:0] mem_addr_q, mem_addr_n;
   logic [7:0]  mem_data_q, mem_data_n;
   logic        mem_we_q, mem_we_n;
`ifdef UART_LOADER_CHECKSUM_EN
   logic [7:0]  csum, csum_n;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         st         <= S_IDLE;
         addr       <= '0;
         len        <= '0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
         mem_we_q   <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
         csum       <= '0;
`endif
      end else begin
         st         <= st_n;
         addr       <= addr_n;
         len        <= len_n;
         mem_addr_q <= mem_addr_n;
         mem_data_q <= mem_data_n;
         mem_we_q   <= mem_we_n;
`ifdef UART_LOADER_CHECKSUM_EN
         csum       <= csum_n;
`endif
      end
   end

   always_comb begin
      st_n       = st;
      addr_n     = addr;
      len_n      = len;
      mem_addr_n = mem_addr_q;
      mem_data_n = mem_data_q;
      mem_we_n   = 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
      csum_n     = csum;
`endif
      // Line errors after DONE are ignored so noise cannot stop a running CPU.
      if (frame_err && st != S_DONE) begin
         st_n = S_ERROR;
      end else if (byte_valid) begin
         case (st)
            S_IDLE, S_DONE, S_ERROR: begin
               if (rx_shift == SYNC_BYTE) begin
                  st_n = S_ADDR_H;
`ifdef UART_LOADER_CHECKSUM_EN
                  csum_n = '0;
`endif
               end
            end
            S_ADDR_H: begin
               addr_n[15:8] = rx_shift;
               st_n         = S_ADDR_L;
            end
            S_ADDR_L: begin
               addr_n[7:0] = rx_shift;
               st_n        = S_LEN_H;
            end
            S_LEN_H: begin
               len_n[15:8] = rx_shift;
               st_n        = S_LEN_L;
            end
            S_LEN_L: begin
               len_n = {len[15:8], rx_shift};
               st_n  = ({len[15:8], rx_shift} == 16'd0) ? S_TAIL : S_DATA;
            end
            S_DATA: begin
               mem_addr_n = addr;
               mem_data_n = rx_shift;
               mem_we_n   = 1'b1;
               addr_n     = addr + 16'd1;
               len_n      = len - 16'd1;
`ifdef UART_LOADER_CHECKSUM_EN
               csum_n     = csum + rx_shift;
`endif
               if (len == 16'd1) st_n = S_TAIL;
            end
`ifdef UART_LOADER_CHECKSUM_EN
            S_CSUM: st_n = (rx_shift == csum) ? S_DONE : S_ERROR;
`endif
            default: st_n = S_IDLE;
         endcase
      end
   end

   assign bus.mem_addr = mem_addr_q;
   assign bus.mem_data = mem_data_q;
   assign bus.mem_we   = mem_we_q;
   assign bus.done     = (st == S_DONE);
   assign bus.error    = (st == S_ERROR);
   assign bus.cpu_hold = (st != S_DONE);
   assign bus.busy     = (st != S_IDLE) && (st != S_DONE) && (st != S_ERROR);

endmodule
